aes_cipher_iter: RTL

Iterative AES encryption core that sits directly downstream of `KeyExpansion`. It consumes the expanded `keyschedule` bus and a 128-bit plaintext block, then executes one full cipher round per clock. After the final round it presents the ciphertext through a valid/ready handshake. One block is in flight at a time. `nk`/`nr` match the `KeyExpansion` instance, so AES-128, AES-192 and AES-256 are all covered.

---
 rtl/aes_cipher_iter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption core, one full round per clock.
// Define AES_CIPHER_KEY_LATCH_EN to capture round keys 1..nr at accept.

module sBox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] b;

    assign b    = ginv(din);
    assign dout = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module aes_cipher_iter #(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:127]           plaintext,
    input  logic [0:128*(nr+1)-1]  keyschedule,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:127]           ciphertext
);
    localparam int CW = $clog2(nr + 1);
    localparam logic [CW-1:0] LAST = CW'(nr);

    if (nr != nk + 6) begin : g_cfg_check
        $error("aes_cipher_iter: nr must equal nk + 6");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} st_e;

    st_e           st_q, st_d;
    logic [0:127]  state_q, state_d;
    logic [CW-1:0] rnd_q, rnd_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [0:127]  sb, sr, mc, rk, rnd_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // byte i sits at row i%4, column i/4
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        sBox u_sbox (
            .din  (state_q[8*i +: 8]),
            .dout (sb[8*i +: 8])
        );
    end

`ifdef AES_CIPHER_KEY_LATCH_EN
    logic [0:128*nr-1] keys_q, keys_d;

    always_comb begin
        rk = '0;
        if (rnd_q != '0)
            rk = keys_q[128*(int'(rnd_q)-1) +: 128];
    end
`else
    assign rk = keyschedule[128*int'(rnd_q) +: 128];
`endif

    assign sr      = shift_rows(sb);
    assign mc      = mix_columns(sr);
    assign rnd_out = ((rnd_q == LAST) ? sr : mc) ^ rk;

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        rnd_d   = rnd_q;
`ifdef AES_CIPHER_KEY_LATCH_EN
        keys_d  = keys_q;
`endif
        unique case (st_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ keyschedule[0:127];
                    rnd_d   = CW'(1);
                    st_d    = ROUND;
`ifdef AES_CIPHER_KEY_LATCH_EN
                    keys_d  = keyschedule[128 +: 128*nr];
`endif
                end
            end
            ROUND: begin
                state_d = rnd_out;
                rnd_d   = rnd_q + CW'(1);
                if (rnd_q == LAST) st_d = DONE;
            end
            DONE: begin
                if (out_ready) st_d = IDLE;
            end
        endcase
        in_ready_d  = (st_d == IDLE);
        out_valid_d = (st_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef AES_CIPHER_KEY_LATCH_EN
            keys_q      <= '0;
`endif
        end else begin
            st_q        <= st_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef AES_CIPHER_KEY_LATCH_EN
            keys_q      <= keys_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign ciphertext = state_q;
endmodule
